approx_mul_inverse_div: RTL and testbench

// - Sequential unsigned divider that inverts the 8x8 multiplier family: given a product z and operand y, recovers x = z / y.
// - Used in error characterisation: feed approximate-multiplier outputs, compare recovered x against the exact operand.
// - Restoring radix-2, one quotient bit per clock, valid/ready handshakes on both sides.

---
 rtl/approx_mul_inverse_div.sv | 176 +++++++++++++++++
 tb/tb_approx_mul_inverse_div.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_inverse_div.sv
// rtl/approx_mul_inverse_div.sv - restoring radix-2 divider that recovers x = z / y from an 8x8 product
//
// Optional feature macro: DIV_ROUND_EN (round-to-nearest quotient, ties up).
//
// Ports:
//   clk        in   1      clock, all logic on rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      dividend/divisor presented
//   in_ready   out  1      idle, operands accepted on in_valid
//   z          in   2*DW   dividend (product)
//   y          in   DW     divisor (known operand)
//   out_valid  out  1      result held until accepted
//   out_ready  in   1      downstream accepts result
//   q          out  DW     quotient (recovered x)
//   r          out  DW     remainder
//   div0       out  1      divisor was zero
//   ovf        out  1      quotient does not fit in DW bits
module approx_mul_inverse_div #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] z,
    input  logic [DW-1:0]   y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   q,
    output logic [DW-1:0]   r,
    output logic            div0,
    output logic            ovf
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [DW-1:0] y_reg;
    logic [DW-1:0] z_lo;
    logic [DW-1:0] rem;
    logic [CW-1:0] cnt;

    logic          capture;
    logic          pre_div0;
    logic          pre_ovf;

    logic [DW:0]   partial;
    logic [DW:0]   diff;
    logic          take;
    logic [DW-1:0] rem_nx;
    logic [DW-1:0] q_nx;
    logic          last_iter;
    logic [DW-1:0] q_fin;
    logic          ovf_fin;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign capture   = in_valid && in_ready;

    // The high half of z is the initial partial remainder; if it already
    // reaches y the quotient cannot fit in DW bits, so skip the iterations.
    assign pre_div0 = (y == '0);
    assign pre_ovf  = !pre_div0 && (z[2*DW-1:DW] >= y);

    // rem < y holds throughout BUSY, so rem_nx always fits in DW bits.
    assign partial   = {rem, z_lo[cnt]};
    assign diff      = partial - {1'b0, y_reg};
    assign take      = (partial >= {1'b0, y_reg});
    assign rem_nx    = take ? diff[DW-1:0] : partial[DW-1:0];
    assign q_nx      = {q[DW-2:0], take};
    assign last_iter = (cnt == '0);

`ifdef DIV_ROUND_EN
    logic [DW:0] rem_x2;
    logic        round_up;
    logic        q_all_ones;

    assign rem_x2     = {rem_nx, 1'b0};
    assign round_up   = (rem_x2 >= {1'b0, y_reg});
    assign q_all_ones = &q_nx;
    // Rounding the largest quotient up would wrap, so saturate and flag it.
    assign q_fin      = (round_up && !q_all_ones) ? (q_nx + {{(DW-1){1'b0}}, 1'b1}) : q_nx;
    assign ovf_fin    = round_up && q_all_ones;
`else
    assign q_fin      = q_nx;
    assign ovf_fin    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nx = (pre_div0 || pre_ovf) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg <= '0;
            z_lo  <= '0;
            rem   <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            div0  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        y_reg <= y;
                        z_lo  <= z[DW-1:0];
                        rem   <= z[2*DW-1:DW];
                        cnt   <= CW'(DW - 1);
                        r     <= '0;
                        if (pre_div0) begin
                            q    <= '1;
                            div0 <= 1'b1;
                            ovf  <= 1'b0;
                        end else if (pre_ovf) begin
                            q    <= '1;
                            div0 <= 1'b0;
                            ovf  <= 1'b1;
                        end else begin
                            q    <= '0;
                            div0 <= 1'b0;
                            ovf  <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    rem <= rem_nx;
                    if (last_iter) begin
                        q   <= q_fin;
                        r   <= rem_nx;
                        ovf <= ovf_fin;
                    end else begin
                        q   <= q_nx;
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mul_inverse_div.sv
// tb/tb_approx_mul_inverse_div.sv - randomized self-checking bench for approx_mul_inverse_div
module tb_approx_mul_inverse_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] z = '0;
    logic [7:0]  y = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        div0;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    approx_mul_inverse_div #(.DW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .z(z), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .r(r), .div0(div0), .ovf(ovf)
    );

    // Reference: plain integer division with the block's flag rules.
    task automatic model(input int zi, input int yi, output int eq, output int er,
                         output bit ed, output bit eo, output bit pre);
        eq = 0; er = 0; ed = 0; eo = 0; pre = 0;
        if (yi == 0) begin
            eq = 255; ed = 1; pre = 1;
        end else if (zi / yi > 255) begin
            eq = 255; eo = 1; pre = 1;
        end else begin
            eq = zi / yi;
            er = zi % yi;
`ifdef DIV_ROUND_EN
            if (2 * er >= yi) begin
                if (eq == 255) eo = 1;
                else eq = eq + 1;
            end
`endif
        end
    endtask

    task automatic do_div(input logic [15:0] zi, input logic [7:0] yi,
                          output logic [7:0] qo, output logic [7:0] ro,
                          output bit d0, output bit ov, output int lat);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout got=%0b want=1", in_ready);
        end
        in_valid = 1'b1; z = zi; y = yi;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        qo = q; ro = r; d0 = div0; ov = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, q, r, div0, ovf} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset got rdy=%0b vld=%0b q=%h r=%h d0=%0b ov=%0b want 1 0 00 00 0 0",
                     in_ready, out_valid, q, r, div0, ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [15:0] tz [6] = '{16'h448E, 16'd1000, 16'h1234, 16'hFF00, 16'h00FF, 16'h0000};
        logic [7:0]  ty [6] = '{8'h5A,    8'd7,     8'h00,   8'h10,   8'h01,   8'h33};
        for (int i = 0; i < 6; i++) begin
            logic [7:0] gq, gr; bit gd, go, ed, eo, pre; int lat, eq, er, elat;
            model(int'(tz[i]), int'(ty[i]), eq, er, ed, eo, pre);
            elat = pre ? 1 : 9;
            do_div(tz[i], ty[i], gq, gr, gd, go, lat);
            checks++;
            if (gq !== 8'(eq) || gr !== 8'(er) || gd !== ed || go !== eo || lat != elat) begin
                errors++;
                $display("FAIL vector%0d z=%h y=%h got q=%h r=%h d0=%0b ov=%0b lat=%0d want q=%h r=%h d0=%0b ov=%0b lat=%0d",
                         i, tz[i], ty[i], gq, gr, gd, go, lat, 8'(eq), 8'(er), ed, eo, elat);
            end
        end
    endtask

    task automatic test_stall();
        int n = 0;
        in_valid = 1'b1; z = 16'h448E; y = 8'h5A;
        @(posedge clk); #1;
        z = 16'h0101; y = 8'h01;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({out_valid, in_ready, q, r, div0, ovf} !== {1'b1, 1'b0, 8'hC3, 8'h00, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall%0d got vld=%0b rdy=%0b q=%h r=%h d0=%0b ov=%0b want 1 0 c3 00 0 0",
                         c, out_valid, in_ready, q, r, div0, ovf);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got vld=%0b rdy=%0b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_abort();
        logic [7:0] gq, gr; bit gd, go; int lat;
        in_valid = 1'b1; z = 16'h448E; y = 8'h5A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, q, r} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL abort got rdy=%0b vld=%0b q=%h r=%h want 1 0 00 00", in_ready, out_valid, q, r);
        end
        do_div(16'd1000, 8'd7, gq, gr, gd, go, lat);
        checks++;
`ifdef DIV_ROUND_EN
        if (gq !== 8'd143 || gr !== 8'd6 || gd || go || lat != 9) begin
`else
        if (gq !== 8'd142 || gr !== 8'd6 || gd || go || lat != 9) begin
`endif
            errors++;
            $display("FAIL after_abort got q=%0d r=%0d d0=%0b ov=%0b lat=%0d", gq, gr, gd, go, lat);
        end
    endtask

    task automatic test_back_to_back();
        int caps[$];
        int vld_q[$];
        out_ready = 1'b1;
        in_valid = 1'b1; z = 16'd1000; y = 8'd7;
        for (int c = 0; c < 30; c++) begin
            if (in_valid && in_ready) caps.push_back(c);
            if (out_valid) vld_q.push_back(int'(q));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (caps.size() < 2 || caps[1] - caps[0] != 10) begin
            errors++;
            $display("FAIL throughput got caps=%0d gap=%0d want gap=10",
                     caps.size(), (caps.size() >= 2) ? caps[1] - caps[0] : -1);
        end
        checks++;
`ifdef DIV_ROUND_EN
        if (vld_q.size() < 2 || vld_q[0] != 143) begin
`else
        if (vld_q.size() < 2 || vld_q[0] != 142) begin
`endif
            errors++;
            $display("FAIL b2b_result got n=%0d q=%0d", vld_q.size(), (vld_q.size() > 0) ? vld_q[0] : -1);
        end
    endtask

    task automatic test_random();
        int bad_exact = 0;
        int bad_any = 0;
        for (int i = 0; i < 2500; i++) begin
            logic [7:0] x8, y8, gq, gr; bit gd, go; int lat;
            x8 = 8'($urandom_range(0, 255));
            y8 = 8'($urandom_range(1, 255));
            do_div(16'(int'(x8) * int'(y8)), y8, gq, gr, gd, go, lat);
            checks++;
            if (gq !== x8 || gr !== 8'h00 || gd || go) begin
                errors++;
                if (bad_exact++ < 5)
                    $display("FAIL rand_exact x=%h y=%h got q=%h r=%h d0=%0b ov=%0b want q=%h r=00",
                             x8, y8, gq, gr, gd, go, x8);
            end
        end
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] z16; logic [7:0] y8, gq, gr; bit gd, go, ed, eo, pre; int lat, eq, er;
            z16 = 16'($urandom_range(0, 65535));
            y8  = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0 && y8 != 0) z16 = 16'($urandom_range(0, int'(y8) * 256 - 1));
            model(int'(z16), int'(y8), eq, er, ed, eo, pre);
            do_div(z16, y8, gq, gr, gd, go, lat);
            checks++;
            if (gq !== 8'(eq) || gr !== 8'(er) || gd !== ed || go !== eo || lat != (pre ? 1 : 9)) begin
                errors++;
                if (bad_any++ < 5)
                    $display("FAIL rand_any z=%h y=%h got q=%h r=%h d0=%0b ov=%0b lat=%0d want q=%h r=%h d0=%0b ov=%0b",
                             z16, y8, gq, gr, gd, go, lat, 8'(eq), 8'(er), ed, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_stall();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
